// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity mode constants and parity helper.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Even parity makes the total count of ones even; odd parity inverts that.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last count of each bit.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign bit_tick = enable && (count == LAST);

    always_ff @(posedge clock) begin
        if (reset || !enable)
            count <= '0;
        else
            count <= bit_tick ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1-style UART transmitter with optional parity and 1 or 2 stop bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    uart_tx_state_t state, state_n;
    logic [7:0] shift_reg, shift_n;
    logic [2:0] bit_idx, idx_n;
    logic       stop_cnt, stop_n;
    logic       par_r, par_n;
    logic       tx_n, busy_n, done_n;
    logic       bit_tick;

    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clock    (clock),
        .reset    (reset),
        .enable   (state != IDLE),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            stop_cnt  <= 1'b0;
            par_r     <= 1'b0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            bit_idx   <= idx_n;
            stop_cnt  <= stop_n;
            par_r     <= par_n;
            tx        <= tx_n;
            tx_busy   <= busy_n;
            tx_done   <= done_n;
        end
    end

    // Outputs are computed one cycle ahead so tx/tx_busy/tx_done come straight from flops.
    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        idx_n   = bit_idx;
        stop_n  = stop_cnt;
        par_n   = par_r;
        tx_n    = tx;
        busy_n  = tx_busy;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (tx_start) begin
                    shift_n = tx_data;
                    par_n   = parity_bit(tx_data, PARITY_MODE);
                    idx_n   = '0;
                    stop_n  = 1'b0;
                    state_n = START;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_n = DATA;
                    tx_n    = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_n = shift_reg >> 1;
                    idx_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                        tx_n    = (PARITY_MODE != PARITY_NONE) ? par_r : 1'b1;
                    end else begin
                        tx_n = shift_reg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (bit_tick) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        stop_n = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: four parameter variants driven in parallel, checked against a frame-level model.
module tb_uart_tx_serializer;

    localparam int CPB = 4;
    localparam int PM[4] = '{0, 1, 2, 0};
    localparam int SB[4] = '{1, 1, 1, 2};

    logic       clock = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_o   [4];
    logic       busy_o [4];
    logic       done_o [4];

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_serializer #(
            .CLKS_PER_BIT (CPB),
            .PARITY_MODE  (PM[g]),
            .STOP_BITS    (SB[g])
        ) dut (
            .clock    (clock),
            .reset    (reset),
            .tx_start (tx_start),
            .tx_data  (tx_data),
            .tx       (tx_o[g]),
            .tx_busy  (busy_o[g]),
            .tx_done  (done_o[g])
        );
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int flen(input int d);
        return (9 + (PM[d] != 0 ? 1 : 0) + SB[d]) * CPB;
    endfunction

    // Frame bit i of byte b on variant d: start, data LSB-first, optional parity, then stop(s).
    function automatic logic exp_bit(input int d, input logic [7:0] b, input int i);
        int ones;
        ones = $countones(b);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9 && PM[d] == 1) return (ones % 2) == 1;
        if (i == 9 && PM[d] == 2) return (ones % 2) == 0;
        return 1'b1;
    endfunction

    // Reference: a frame is just "cycles since accept"; line level is frame bit n/CPB.
    bit         m_act  [4];
    bit         m_done [4];
    int         m_n    [4];
    logic [7:0] m_byte [4];

    always @(posedge clock) begin
        for (int d = 0; d < 4; d++) begin
            if (reset) begin
                m_act[d]  = 1'b0;
                m_done[d] = 1'b0;
            end else if (!m_act[d]) begin
                m_done[d] = 1'b0;
                if (tx_start) begin
                    m_act[d]  = 1'b1;
                    m_n[d]    = 0;
                    m_byte[d] = tx_data;
                end
            end else begin
                m_n[d]++;
                if (m_n[d] == flen(d)) begin
                    m_act[d]  = 1'b0;
                    m_done[d] = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            for (int d = 0; d < 4; d++) begin
                logic e_tx;
                e_tx = m_act[d] ? exp_bit(d, m_byte[d], m_n[d] / CPB) : 1'b1;
                check($sformatf("model_dut%0d{tx,busy,done}", d),
                      {29'd0, tx_o[d], busy_o[d], done_o[d]},
                      {29'd0, e_tx, m_act[d], m_done[d]});
            end
        end
    end

    typedef struct {
        logic [7:0]  data;
        int          sel;
        bit          glitch;
        logic [11:0] bits;
        int          nbits;
        int          len;
    } vec_t;

    vec_t vecs[6];

    // Sends one byte, samples variant sel at mid-bit, and checks frame bits, done timing and busy length.
    task automatic run_frame(input vec_t v);
        logic [11:0] rx;
        int done_at, busy_cnt, done_cnt;
        rx = '0;
        done_at = -1;
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clock);
        tx_data  = v.data;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (n % CPB == CPB / 2 && n / CPB < v.nbits) rx[n / CPB] = tx_o[v.sel];
            if (done_o[v.sel]) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (busy_o[v.sel]) busy_cnt++;
            if (v.glitch && n == 14) begin
                tx_start = 1'b1;
                tx_data  = 8'h11;
            end
            if (v.glitch && n == 15) tx_start = 1'b0;
            @(negedge clock);
        end
        check($sformatf("bits_%02h_dut%0d", v.data, v.sel), int'(rx), int'(v.bits));
        check($sformatf("done_at_%02h_dut%0d", v.data, v.sel), done_at, v.len);
        check($sformatf("busy_len_%02h_dut%0d", v.data, v.sel), busy_cnt, v.len);
        check($sformatf("done_cnt_%02h_dut%0d", v.data, v.sel), done_cnt, 1);
    endtask

    initial begin
        logic [7:0] b1, b2;
        int dcnt, hold;
        vecs[0] = '{8'hA5, 0, 1'b0, 12'b00_1101001010, 10, 40};
        vecs[1] = '{8'h07, 1, 1'b0, 12'b0_11000001110, 11, 44};
        vecs[2] = '{8'h07, 2, 1'b0, 12'b0_10000001110, 11, 44};
        vecs[3] = '{8'hFF, 3, 1'b0, 12'b0_11111111110, 11, 44};
        vecs[4] = '{8'h3C, 0, 1'b1, 12'b00_1001111000, 10, 40};
        vecs[5] = '{8'h81, 0, 1'b0, 12'b00_1100000010, 10, 40};

        reset    = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        @(negedge clock);
        chk_en = 1'b1;
        repeat (2) @(negedge clock);
        for (int d = 0; d < 4; d++)
            check($sformatf("reset_dut%0d{tx,busy,done}", d),
                  {29'd0, tx_o[d], busy_o[d], done_o[d]}, 32'b100);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Back-to-back frames with tx_start held high; data changes after the first accept.
        b1 = '0;
        b2 = '0;
        dcnt = 0;
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clock);
        tx_data = 8'h0F;
        for (int n = 0; n < 100; n++) begin
            if (n == 41) tx_start = 1'b0;
            if (done_o[0]) dcnt++;
            if (n % CPB == CPB / 2 && n / CPB >= 1 && n / CPB <= 8) b1[n / CPB - 1] = tx_o[0];
            if (n >= 41 && (n - 41) % CPB == CPB / 2 && (n - 41) / CPB >= 1 && (n - 41) / CPB <= 8)
                b2[(n - 41) / CPB - 1] = tx_o[0];
            if (n == 40) check("b2b_gap_tx", int'(tx_o[0]), 1);
            if (n == 41) check("b2b_second_start_tx", int'(tx_o[0]), 0);
            @(negedge clock);
        end
        check("b2b_byte1", int'(b1), 8'h55);
        check("b2b_byte2", int'(b2), 8'h0F);
        check("b2b_done_cnt", dcnt, 2);

        // Reset while DUT0 is on data bit 3.
        tx_data  = 8'hC3;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        repeat (17) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        for (int d = 0; d < 4; d++)
            check($sformatf("midreset_dut%0d{tx,busy}", d), {30'd0, tx_o[d], busy_o[d]}, 32'b10);
        reset = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 50; n++) begin
            if (done_o[0]) dcnt++;
            @(negedge clock);
        end
        check("midreset_no_done", dcnt, 0);
        run_frame(vecs[5]);

        // Random traffic, including held-start bursts and rare resets, checked by the model.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            reset   = ($urandom_range(0, 799) == 0);
            tx_data = 8'($urandom);
            if (hold > 0) begin
                tx_start = 1'b1;
                hold--;
            end else begin
                tx_start = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 99) == 0) hold = $urandom_range(1, 90);
            end
        end
        reset    = 1'b0;
        tx_start = 1'b0;
        repeat (60) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
